// File: rtl/lifo_fifo_buffer.sv
// Parameterised storage buffer: Mode 0 = LIFO stack, Mode 1 = FIFO queue, with occupancy
// count, threshold flags and overflow/underflow pulses. Define LIFO_PEEK_EN to add Peek_out.
module lifo_fifo_buffer #(
   parameter int unsigned Input_Data_Width    = 8,
   parameter int unsigned LIFO_Depth          = 8,
   parameter int unsigned Mode                = 0,
   parameter int unsigned Almost_Full_Thresh  = 6,
   parameter int unsigned Almost_Empty_Thresh = 2
) (
   input  logic                                clk,
   input  logic                                reset,
   input  logic                                Write,
   input  logic                                Read,
   input  logic [Input_Data_Width-1:0]         Data_in,
   output logic [Input_Data_Width-1:0]         Data_out,
   output logic                                Data_valid,
   output logic                                LIFO_Full,
   output logic                                LIFO_Empty,
   output logic                                Almost_Full,
   output logic                                Almost_Empty,
   output logic [$clog2(LIFO_Depth+1)-1:0]     Count,
`ifdef LIFO_PEEK_EN
   output logic [Input_Data_Width-1:0]         Peek_out,
`endif
   output logic                                Overflow,
   output logic                                Underflow
);

   localparam int unsigned CntW = $clog2(LIFO_Depth + 1);
   localparam int unsigned PtrW = $clog2(LIFO_Depth);

   logic [Input_Data_Width-1:0] mem_q [LIFO_Depth];

   logic [CntW-1:0]             count_q, count_d;
   logic [PtrW-1:0]             wr_ptr_q, wr_ptr_d;
   logic [PtrW-1:0]             rd_ptr_q, rd_ptr_d;
   logic [Input_Data_Width-1:0] data_out_q, data_out_d;
   logic                        data_valid_q, overflow_q, underflow_q;

   logic            empty, full, rd_acc, wr_acc;
   logic [PtrW-1:0] rd_addr, wr_addr;

   function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] ptr);
      return (ptr == PtrW'(LIFO_Depth - 1)) ? '0 : ptr + PtrW'(1);
   endfunction

   assign empty  = (count_q == '0);
   assign full   = (count_q == CntW'(LIFO_Depth));
   assign rd_acc = Read & ~empty;
   // A full buffer still takes a write when the same cycle's read frees the slot.
   assign wr_acc = Write & (~full | rd_acc);

   always_comb begin
      rd_addr  = rd_ptr_q;
      wr_addr  = wr_ptr_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (Mode == 0) begin
         // Simultaneous push+pop overwrites the popped top slot.
         rd_addr = PtrW'(count_q - CntW'(1));
         wr_addr = rd_acc ? rd_addr : PtrW'(count_q);
      end else begin
         if (wr_acc) wr_ptr_d = ptr_inc(wr_ptr_q);
         if (rd_acc) rd_ptr_d = ptr_inc(rd_ptr_q);
      end
      unique case ({wr_acc, rd_acc})
         2'b10:   count_d = count_q + CntW'(1);
         2'b01:   count_d = count_q - CntW'(1);
         default: count_d = count_q;
      endcase
      data_out_d = rd_acc ? mem_q[rd_addr] : data_out_q;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         count_q      <= '0;
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
         data_out_q   <= '0;
         data_valid_q <= 1'b0;
         overflow_q   <= 1'b0;
         underflow_q  <= 1'b0;
      end else begin
         count_q      <= count_d;
         wr_ptr_q     <= wr_ptr_d;
         rd_ptr_q     <= rd_ptr_d;
         data_out_q   <= data_out_d;
         data_valid_q <= rd_acc;
         overflow_q   <= Write & ~wr_acc;
         underflow_q  <= Read & empty;
      end
   end

   always_ff @(posedge clk) begin
      if (wr_acc) mem_q[wr_addr] <= Data_in;
   end

   assign Data_out     = data_out_q;
   assign Data_valid   = data_valid_q;
   assign Overflow     = overflow_q;
   assign Underflow    = underflow_q;
   assign Count        = count_q;
   assign LIFO_Empty   = empty;
   assign LIFO_Full    = full;
   assign Almost_Full  = (count_q >= CntW'(Almost_Full_Thresh));
   assign Almost_Empty = (count_q <= CntW'(Almost_Empty_Thresh));

`ifdef LIFO_PEEK_EN
   assign Peek_out = empty ? '0 : mem_q[rd_addr];
`endif

endmodule
